uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmit line (txd) between REQ_NUM byte requesters (e.g. core MMIO port,
//  debug/trace port). Round-robin picks one requester, latches its byte and serialises one 8N1 frame
//  at SYS_FREQ/UART_BAUD. Sits between the requesters inside core_top and the top-level txd pin.
// PARAMETERS
//  REQ_NUM   2                         number of requesters, 1..8
//  FREQ_DIV  `SYS_FREQ / `UART_BAUD    clock cycles per UART bit, >= 2 (elaboration-time $error otherwise)
// PORTS
//  clk         in   1           system clock, all logic on posedge
//  rst         in   1           reset, synchronous, active-low
//  req_valid   in   REQ_NUM     requester i has a byte pending; must hold valid+data until ready
//  req_data    in   REQ_NUM*8   byte of requester i at [i*8 +: 8]
//  req_ready   out  REQ_NUM     one-hot; byte of requester i accepted on this edge (valid & ready)
//  txd         out  1           serial output, idle high
//  busy        out  1           frame in progress (state != IDLE)
//  grant_id    out  $clog2(REQ_NUM) (min 1)  requester whose byte is currently on txd
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, txd=1, busy=0, grant_id=0, last_grant=REQ_NUM-1,
//   bit/baud counters=0; frame in progress is aborted, txd high on the next edge. req_ready=0 while rst==0.
//  States: IDLE -> START -> DATA -> STOP -> IDLE.
//  IDLE: txd=1. Winner = first i with req_valid[i], searching last_grant+1, +2, ... modulo REQ_NUM.
//   req_ready[winner]=1 combinationally in IDLE only; all other req_ready=0. On that edge: latch byte,
//   grant_id=winner, last_grant=winner, go START. No valid -> stay IDLE, pointer unchanged.
//  START: txd=0 for exactly FREQ_DIV cycles, then DATA.
//  DATA: 8 bits, LSB first, each FREQ_DIV cycles; bit counter 0..7; after bit 7 -> STOP.
//  STOP: txd=1 for FREQ_DIV cycles, then IDLE.
//  Timing: txd falls the cycle after the accepting edge; frame = 10*FREQ_DIV cycles; back-to-back
//   frames separated by exactly one IDLE cycle (accept cycle), i.e. period 10*FREQ_DIV+1.
//  Baud counter: 0..FREQ_DIV-1, width $clog2(FREQ_DIV); wraps to 0 at each bit boundary; reset on accept.
//  txd is a registered output (no combinational path from inputs).
//  Requester dropping valid without ready: no transfer, no side effect. req_data change while not
//   ready: ignored. Latched byte is stable for the whole frame regardless of inputs.
//  Simultaneous valids: strict alternation by round-robin; a requester never waits > REQ_NUM-1 frames.
//  REQ_NUM==1: winner always 0, grant_id width 1, stays 0.
// STRUCTURE
//  uart_pkg: typedef enum logic[1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
//   localparam UART_DATA_BITS=8, UART_FRAME_BITS=10.
//  One sub-module: rr_arbiter #(.N(REQ_NUM)) (req, last_grant -> one-hot grant, grant index), pure
//   combinational; arbiter FSM, counters and shift register stay in uart_tx_arbiter.
// TESTING  (bench decodes txd: on falling edge wait FREQ_DIV per bit, sample 8 bits, then stop;
//   use FREQ_DIV=16 for speed plus one run at the default)
//  1 Reset: hold rst=0 5 cycles with req_valid=2'b11 -> txd=1, busy=0, req_ready=0 throughout.
//  2 Single byte: req0 valid, data 8'h48 -> req_ready[0] 1 cycle, txd low next cycle, decode 'H',
//    busy high exactly 160 cycles, txd=1 afterwards.
//  3 Contention: req0=8'h41, req1=8'h42 held valid -> frames in order 'A','B','A','B'... (last_grant
//    reset = 1 so req0 first); each frame start 161 cycles apart.
//  4 Back-to-back single requester: stream "hello\n" on req1 -> exact string decoded, gap 1 cycle.
//  5 Reset mid-frame: assert rst=0 during DATA bit 3 -> txd=1 on next edge, after release new req
//    8'h5A decodes correctly, no remnant of aborted frame.
//  6 Input stability: change req_data[7:0] and drop req_valid[0] mid-frame -> transmitted byte
//    unchanged; dropped request never acknowledged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    // Width of an index into n items, never below one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last grant.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IdW = idx_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] last_grant_i,
    output logic [N-1:0]   grant_o,
    output logic [IdW-1:0] grant_idx_o
);

    logic        found;
    int unsigned cand;

    // Walk last+1, last+2, ... modulo N; first requester seen wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_grant_i) + k) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && (i == cand) && req_i[i]) begin
                    grant_o[i]  = 1'b1;
                    grant_idx_o = IdW'(i);
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmit line between REQ_NUM byte requesters.
`ifndef SYS_FREQ
`define SYS_FREQ 50000000
`endif
`ifndef UART_BAUD
`define UART_BAUD 115200
`endif

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned REQ_NUM  = 2,
    parameter int unsigned FREQ_DIV = `SYS_FREQ / `UART_BAUD
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQ_NUM-1:0]              req_valid,
    input  logic [REQ_NUM*8-1:0]            req_data,
    output logic [REQ_NUM-1:0]              req_ready,
    output logic                            txd,
    output logic                            busy,
    output logic [idx_width(REQ_NUM)-1:0]   grant_id
);

    localparam int unsigned IdW   = idx_width(REQ_NUM);
    localparam int unsigned BaudW = $clog2(FREQ_DIV);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(FREQ_DIV - 1);
    localparam logic [2:0] BitLast = 3'(UART_DATA_BITS - 1);

    if (FREQ_DIV < 2) begin : g_bad_div
        $error("uart_tx_arbiter: FREQ_DIV must be >= 2");
    end
    if ((REQ_NUM < 1) || (REQ_NUM > 8)) begin : g_bad_req
        $error("uart_tx_arbiter: REQ_NUM must be 1..8");
    end

    uart_state_t                state_q;
    logic [BaudW-1:0]           baud_q;
    logic [2:0]                 bit_q;
    logic [UART_DATA_BITS-1:0]  shift_q;
    logic                       txd_q;
    logic [IdW-1:0]             grant_q;
    logic [IdW-1:0]             last_q;

    logic [REQ_NUM-1:0]         arb_grant;
    logic [IdW-1:0]             arb_idx;
    logic [UART_DATA_BITS-1:0]  sel_byte;
    logic                       accept;
    logic                       bit_end;

    rr_arbiter #(
        .N (REQ_NUM)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx)
    );

    // Handshake only offered while idle and out of reset.
    always_comb begin
        req_ready = (rst && (state_q == UART_IDLE)) ? arb_grant : '0;
        accept    = |req_ready;
        bit_end   = (baud_q == BaudLast);
        sel_byte  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (arb_grant[i]) begin
                sel_byte = req_data[i*UART_DATA_BITS +: UART_DATA_BITS];
            end
        end
    end

    // Frame FSM with baud/bit counters, latched byte and registered txd.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            grant_q <= '0;
            last_q  <= IdW'(REQ_NUM - 1);
        end else begin
            unique case (state_q)
                UART_IDLE: begin
                    txd_q <= 1'b1;
                    if (accept) begin
                        shift_q <= sel_byte;
                        grant_q <= arb_idx;
                        last_q  <= arb_idx;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= 1'b0;
                        state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= UART_DATA;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                UART_DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == BitLast) begin
                            txd_q   <= 1'b1;
                            state_q <= UART_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                UART_STOP: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= UART_IDLE;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= UART_IDLE;
                end
            endcase
        end
    end

    assign txd      = txd_q;
    assign busy     = (state_q != UART_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected bytes, a txd monitor decodes and compares.
module tb_uart_tx_arbiter;

    localparam int unsigned Fd     = 16;
    localparam int unsigned DefDiv = 434;   // 50 MHz / 115200 baud
    localparam int unsigned Period = 10 * Fd + 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        txd;
    logic        busy;
    logic [0:0]  grant_id;

    logic        rst_b;
    logic [0:0]  valid_b;
    logic [7:0]  data_b;
    logic [0:0]  ready_b;
    logic        txd_b;
    logic        busy_b;
    logic [0:0]  gid_b;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b1;
    bit          def_done = 1'b0;

    logic [7:0]  exp_byte_q[$];
    logic [0:0]  exp_id_q[$];
    int unsigned start_q[$];

    uart_tx_arbiter #(
        .REQ_NUM  (2),
        .FREQ_DIV (Fd)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    uart_tx_arbiter #(
        .REQ_NUM (1)
    ) u_def (
        .clk       (clk),
        .rst       (rst_b),
        .req_valid (valid_b),
        .req_data  (data_b),
        .req_ready (ready_b),
        .txd       (txd_b),
        .busy      (busy_b),
        .grant_id  (gid_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int idx);
        int n;
        n = 0;
        #1;
        while ((req_ready[idx] !== 1'b1) && (n < 2000)) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: requester %0d never got ready", idx);
        end else begin
            check("ready_onehot", 32'(req_ready), 32'(1) << idx);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        req_data[idx*8 +: 8] = b;
        req_valid[idx] = 1'b1;
        exp_byte_q.push_back(b);
        exp_id_q.push_back(idx[0]);
        wait_ready(idx);
        tick();
        req_valid[idx] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_byte_q.size() != 0) && (n < 5000)) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d frames outstanding", exp_byte_q.size());
        end
        repeat (Fd + 2) tick();
    endtask

    task automatic check_gaps(input string name, input int frames);
        check({name, "_frames"}, start_q.size(), frames);
        for (int i = 0; i + 1 < start_q.size(); i++) begin
            check({name, "_period"}, start_q[i+1] - start_q[i], Period);
        end
    endtask

    // Monitor: decode each frame at mid-bit and compare against the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && (txd === 1'b0)) begin
                start_q.push_back(cyc);
                repeat (Fd / 2) @(negedge clk);
                check("start_bit", 32'(txd), 0);
                if (exp_id_q.size() != 0) begin
                    check("grant_id", 32'(grant_id), 32'(exp_id_q.pop_front()));
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (Fd) @(negedge clk);
                    b[i] = txd;
                end
                repeat (Fd) @(negedge clk);
                check("stop_bit", 32'(txd), 1);
                if (exp_byte_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %02h expected no frame", b);
                end else begin
                    check("frame_byte", 32'(b), 32'(exp_byte_q.pop_front()));
                end
            end
        end
    end

    // Default-divider, single-requester instance: one frame decoded inline.
    initial begin : default_run
        logic [7:0] b;
        int n;
        rst_b   = 1'b0;
        valid_b = 1'b0;
        data_b  = 8'hC5;
        repeat (3) @(posedge clk);
        #1;
        rst_b   = 1'b1;
        valid_b = 1'b1;
        #1;
        n = 0;
        while ((ready_b !== 1'b1) && (n < 100)) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("def_ready", 32'(ready_b), 1);
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        check("def_txd_start", 32'(txd_b), 0);
        check("def_grant_id", 32'(gid_b), 0);
        repeat (DefDiv / 2) @(posedge clk);
        #1;
        check("def_start_bit", 32'(txd_b), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (DefDiv) @(posedge clk);
            #1;
            b[i] = txd_b;
        end
        repeat (DefDiv) @(posedge clk);
        #1;
        check("def_stop_bit", 32'(txd_b), 1);
        check("def_byte", 32'(b), 32'h0C5);
        repeat (DefDiv) @(posedge clk);
        #1;
        check("def_idle_busy", 32'(busy_b), 0);
        check("def_idle_txd", 32'(txd_b), 1);
        def_done = 1'b1;
    end

    initial begin : stimulus
        int n;
        int acks;
        string s;

        // Reset holds everything idle despite pending requests.
        rst       = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_txd", 32'(txd), 1);
            check("rst_busy", 32'(busy), 0);
            check("rst_ready", 32'(req_ready), 0);
        end
        check("rst_grant_id", 32'(grant_id), 0);
        rst       = 1'b1;
        req_valid = 2'b00;
        tick();

        // Single byte on requester 0.
        req_data[7:0] = 8'h48;
        req_valid[0]  = 1'b1;
        exp_byte_q.push_back(8'h48);
        exp_id_q.push_back(1'b0);
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        check("single_txd_fall", 32'(txd), 0);
        check("single_ready_off", 32'(req_ready), 0);
        n = 0;
        while ((busy === 1'b1) && (n < 400)) begin
            n++;
            tick();
        end
        check("single_busy_cycles", n, 160);
        check("single_txd_idle", 32'(txd), 1);
        drain();

        // Contention from reset: strict alternation starting at requester 0.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start_q.delete();
        req_data  = {8'h42, 8'h41};
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp_byte_q.push_back((f % 2 == 0) ? 8'h41 : 8'h42);
            exp_id_q.push_back(f[0]);
        end
        for (int f = 0; f < 4; f++) begin
            wait_ready(f % 2);
            tick();
        end
        req_valid = 2'b00;
        drain();
        check_gaps("contention", 4);

        // Back-to-back stream on requester 1.
        start_q.delete();
        s = "hello\n";
        for (int i = 0; i < s.len(); i++) begin
            send(1, s[i]);
        end
        drain();
        check_gaps("stream", 6);

        // Reset during data bit 3 aborts the frame.
        mon_en        = 1'b0;
        tick();
        req_data[7:0] = 8'hA5;
        req_valid[0]  = 1'b1;
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        repeat (Fd * 4 + Fd / 2 - 1) tick();
        check("abort_bit3", 32'(txd), 0);
        rst       = 1'b0;
        req_valid = 2'b11;
        tick();
        check("abort_txd", 32'(txd), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(req_ready), 0);
        tick();
        rst       = 1'b1;
        req_valid = 2'b00;
        tick();
        start_q.delete();
        mon_en = 1'b1;
        send(0, 8'h5A);
        drain();
        check_gaps("after_abort", 1);

        // Data change and valid drop mid-frame leave the frame untouched.
        req_data[7:0] = 8'h3C;
        req_valid[0]  = 1'b1;
        exp_byte_q.push_back(8'h3C);
        exp_id_q.push_back(1'b0);
        wait_ready(0);
        tick();
        req_data[7:0] = 8'hFF;
        acks = 0;
        for (int i = 0; i < 80; i++) begin
            if (req_ready !== 2'b00) acks++;
            tick();
        end
        req_valid[0] = 1'b0;
        n = 0;
        while ((busy === 1'b1) && (n < 400)) begin
            if (req_ready !== 2'b00) acks++;
            n++;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            if ((req_ready !== 2'b00) || (busy !== 1'b0)) acks++;
            tick();
        end
        check("dropped_never_acked", acks, 0);
        drain();

        n = 0;
        while (!def_done && (n < 10000)) begin
            tick();
            n++;
        end
        if (!def_done) begin
            checks++;
            errors++;
            $display("FAIL default_run_timeout: default-divider frame not finished");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
